// File: rtl/bcd_pkg.sv
// Shared BCD types, digit limits and nibble validation for the bcd_counter slice.
package bcd_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } count_mode_e;

  function automatic logic bcd_valid(input bcd_digit_t nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One combinational BCD digit stage: increments or decrements on cin and reports carry/borrow.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t d,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t q,
  output logic       cout
);

  always_comb begin
    q    = d;
    cout = 1'b0;
    if (cin) begin
      if (up) begin
        if (d == BCD_MAX) begin
          q    = BCD_MIN;
          cout = 1'b1;
        end else begin
          q = d + 4'd1;
        end
      end else begin
        if (d == BCD_MIN) begin
          q    = BCD_MAX;
          cout = 1'b1;
        end else begin
          q = d - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit packed-BCD up/down event counter with load, clear and edge/level enable.
// Define BCD_COUNTER_SATURATE_EN to saturate at the ends and expose the sticky sat output.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS            = 8,
  parameter bit          EDGE_MODE_DEFAULT = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  mode_wr,
  input  logic                  mode_edge,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  wrap,
  output logic                  load_err
`ifdef BCD_COUNTER_SATURATE_EN
  ,
  output logic                  sat
`endif
);

  logic [4*DIGITS-1:0] count_q, count_d;
  logic [4*DIGITS-1:0] count_step;
  logic [DIGITS:0]     carry;
  logic                wrap_q, wrap_d;
  logic                load_err_q, load_err_d;
  logic                en_q;
  count_mode_e         mode_q, mode_d;
  logic                step;
  logic                load_ok;
`ifdef BCD_COUNTER_SATURATE_EN
  logic                sat_q, sat_d;
`endif

  // carry[DIGITS] is high exactly when the step crosses the all-9s / all-0s boundary
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .d    (count_q[4*i +: 4]),
      .up   (up_dn),
      .cin  (carry[i]),
      .q    (count_step[4*i +: 4]),
      .cout (carry[i+1])
    );
  end

  always_comb begin
    step    = (mode_q == MODE_EDGE) ? (en & ~en_q) : en;
    load_ok = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_valid(load_val[4*i +: 4])) load_ok = 1'b0;
    end

    mode_d     = mode_wr ? count_mode_e'(mode_edge) : mode_q;
    count_d    = count_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
`ifdef BCD_COUNTER_SATURATE_EN
    sat_d      = sat_q;
`endif

    if (clear) begin
      count_d = '0;
`ifdef BCD_COUNTER_SATURATE_EN
      sat_d   = 1'b0;
`endif
    end else if (load) begin
      // a rejected load still consumes the cycle, so a coincident step is dropped
      if (load_ok) begin
        count_d = load_val;
`ifdef BCD_COUNTER_SATURATE_EN
        sat_d   = 1'b0;
`endif
      end else begin
        load_err_d = 1'b1;
      end
    end else if (step) begin
      wrap_d = carry[DIGITS];
`ifdef BCD_COUNTER_SATURATE_EN
      if (carry[DIGITS]) sat_d = 1'b1;
      else               count_d = count_step;
`else
      count_d = count_step;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
      en_q       <= 1'b0;
      mode_q     <= count_mode_e'(EDGE_MODE_DEFAULT);
`ifdef BCD_COUNTER_SATURATE_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
      en_q       <= en;
      mode_q     <= mode_d;
`ifdef BCD_COUNTER_SATURATE_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign load_err = load_err_q;
`ifdef BCD_COUNTER_SATURATE_EN
  assign sat      = sat_q;
`endif

endmodule

// File: tb/tb_bcd_counter.sv
// Self-checking bench for bcd_counter (DIGITS=4): directed plan plus randomized traffic vs. a decimal model.
module tb_bcd_counter;

  localparam int unsigned DIGITS = 4;
  localparam int          MAXV   = 9999;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                en = 1'b0;
  logic                mode_wr = 1'b0;
  logic                mode_edge = 1'b0;
  logic                up_dn = 1'b1;
  logic                clear = 1'b0;
  logic                load = 1'b0;
  logic [4*DIGITS-1:0] load_val = '0;
  logic [4*DIGITS-1:0] count;
  logic                wrap;
  logic                load_err;
`ifdef BCD_COUNTER_SATURATE_EN
  logic                sat;
`endif

  bcd_counter #(
    .DIGITS            (DIGITS),
    .EDGE_MODE_DEFAULT (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode_wr   (mode_wr),
    .mode_edge (mode_edge),
    .up_dn     (up_dn),
    .clear     (clear),
    .load      (load),
    .load_val  (load_val),
    .count     (count),
    .wrap      (wrap),
    .load_err  (load_err)
`ifdef BCD_COUNTER_SATURATE_EN
    ,
    .sat       (sat)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: count kept as a plain decimal integer
  int m_count = 0;
  bit m_en_q  = 1'b0;
  bit m_mode  = 1'b1;
  bit m_wrap  = 1'b0;
  bit m_err   = 1'b0;
  bit m_sat   = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          t;
    t = v;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit nibbles_ok(input logic [15:0] v);
    for (int i = 0; i < 4; i++) if (((v >> (4*i)) & 16'hF) > 16'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int from_bcd(input logic [15:0] v);
    int s, w;
    s = 0;
    w = 1;
    for (int i = 0; i < 4; i++) begin
      s += int'((v >> (4*i)) & 16'hF) * w;
      w *= 10;
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    bit s;
    if (reset) begin
      m_count = 0; m_wrap = 0; m_err = 0; m_en_q = 0; m_mode = 1'b1; m_sat = 0;
      return;
    end
    s      = m_mode ? (en && !m_en_q) : en;
    m_wrap = 0;
    m_err  = 0;
    if (clear) begin
      m_count = 0;
      m_sat   = 0;
    end else if (load) begin
      if (nibbles_ok(load_val)) begin
        m_count = from_bcd(load_val);
        m_sat   = 0;
      end else begin
        m_err = 1;
      end
    end else if (s) begin
      if (up_dn && m_count == MAXV) begin
        m_wrap = 1;
`ifdef BCD_COUNTER_SATURATE_EN
        m_sat = 1;
`else
        m_count = 0;
`endif
      end else if (!up_dn && m_count == 0) begin
        m_wrap = 1;
`ifdef BCD_COUNTER_SATURATE_EN
        m_sat = 1;
`else
        m_count = MAXV;
`endif
      end else begin
        m_count = up_dn ? m_count + 1 : m_count - 1;
      end
    end
    m_en_q = en;
    if (mode_wr) m_mode = mode_edge;
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    check("count", 32'(count), 32'(to_bcd(m_count)));
    check("wrap", 32'(wrap), 32'(m_wrap));
    check("load_err", 32'(load_err), 32'(m_err));
`ifdef BCD_COUNTER_SATURATE_EN
    check("sat", 32'(sat), 32'(m_sat));
`endif
  endtask

  task automatic set_idle();
    reset = 0; en = 0; mode_wr = 0; clear = 0; load = 0;
  endtask

  initial begin
    // Reset
    reset = 1;
    tick(); tick();
    check("reset_count", 32'(count), 32'h0);

    // Edge mode: holding en yields one step, then nine toggles
    set_idle();
    en = 1;
    for (int i = 0; i < 10; i++) tick();
    check("edge_hold", 32'(count), 32'h0001);
    for (int i = 0; i < 9; i++) begin
      en = 0; tick();
      en = 1; tick();
    end
    check("edge_toggle", 32'(count), 32'h0010);

    // Level mode, carry ripple
    set_idle();
    mode_wr = 1; mode_edge = 0; tick();
    mode_wr = 0; load = 1; load_val = 16'h0998; tick();
    load = 0; en = 1; up_dn = 1;
    tick(); check("lvl_0999", 32'(count), 32'h0999);
    tick(); check("lvl_1000", 32'(count), 32'h1000);
    tick(); check("lvl_1001", 32'(count), 32'h1001);
    check("lvl_nowrap", 32'(wrap), 32'h0);

    // Boundary up from 9999 and down from 0000
    set_idle();
    load = 1; load_val = 16'h9999; tick();
    load = 0; en = 1; up_dn = 1; tick();
`ifdef BCD_COUNTER_SATURATE_EN
    check("up_sat", 32'(count), 32'h9999);
`else
    check("up_wrap", 32'(count), 32'h0000);
`endif
    check("up_wrap_pulse", 32'(wrap), 32'h1);
    en = 0; tick();
    check("up_wrap_end", 32'(wrap), 32'h0);
    clear = 1; tick();
    clear = 0; en = 1; up_dn = 0; tick();
`ifdef BCD_COUNTER_SATURATE_EN
    check("dn_sat", 32'(count), 32'h0000);
`else
    check("dn_wrap", 32'(count), 32'h9999);
`endif
    check("dn_wrap_pulse", 32'(wrap), 32'h1);
    en = 0; tick();

    // Rejected load, then load beats a coincident step
    load = 1; load_val = 16'h12A4; tick();
    check("bad_load_err", 32'(load_err), 32'h1);
    load_val = 16'h1234; en = 1; up_dn = 1; tick();
    check("load_over_step", 32'(count), 32'h1234);

    // Reset with en high in edge mode
    set_idle();
    mode_wr = 1; mode_edge = 1; tick();
    mode_wr = 0; en = 1; tick(); tick();
    reset = 1; tick();
    check("rst_mid", 32'(count), 32'h0);
    reset = 0; tick();
    check("rst_release", 32'(count), 32'h0001);

`ifdef BCD_COUNTER_SATURATE_EN
    set_idle();
    mode_wr = 1; mode_edge = 0; tick();
    mode_wr = 0; load = 1; load_val = 16'h9999; tick();
    load = 0; en = 1; up_dn = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sat_hold", 32'(count), 32'h9999);
      check("sat_wrap", 32'(wrap), 32'h1);
    end
    en = 0; tick();
    check("sat_sticky", 32'(sat), 32'h1);
    clear = 1; tick();
    check("sat_cleared", 32'(sat), 32'h0);
`endif

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      logic [15:0] v;
      reset     = ($urandom_range(63) == 0);
      clear     = ($urandom_range(31) == 0);
      load      = ($urandom_range(15) == 0);
      mode_wr   = ($urandom_range(15) == 0);
      mode_edge = 1'($urandom);
      en        = ($urandom_range(3) != 0);
      up_dn     = ($urandom_range(4) != 0) ? (i % 400 < 200) : 1'($urandom);
      case ($urandom_range(3))
        0: v = 16'h9999;
        1: v = 16'h0000;
        2: v = 16'($urandom);
        default: v = to_bcd(int'($urandom_range(9999)));
      endcase
      load_val = v;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/bcd_counter.md
Name: bcd_counter

Overview:
- Parametrised multi-digit packed-BCD event counter with ripple carry/borrow across all digits.
- Supports up and down counting, parallel load, and synchronous clear.
- Selectable edge-triggered or level-triggered count enable.
- Feeds the seven-segment display path and board-level event statistics.
- Successor to the fixed 8-digit, edge-only, up-only decimal counter.

Parameters:
- DIGITS, 8, number of BCD digits (1..16); count width is 4*DIGITS.
- EDGE_MODE_DEFAULT, 1, value of the internal mode register after reset (1 = edge, 0 = level).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count request.
- mode_wr  in  1  writes mode_edge into the internal mode register.
- mode_edge  in  1  new mode: 1 = one step per rising edge of en, 0 = one step per cycle while en is high.
- up_dn  in  1  direction: 1 = increment, 0 = decrement.
- clear  in  1  synchronous clear of count.
- load  in  1  parallel load request.
- load_val  in  4*DIGITS  packed BCD load value; digit 0 is in bits [3:0].
- count  out  4*DIGITS  current packed BCD value.
- wrap  out  1  one-cycle pulse on the cycle count wraps (or saturates).
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset values: count = 0, wrap = 0, load_err = 0, en_q = 0, mode register = EDGE_MODE_DEFAULT.
- en_q resets to 0, so en already high at reset release produces exactly one step in edge mode.
- step is asserted when:
  - edge mode: en && !en_q;
  - level mode: en.
- en_q <= en every cycle, independent of all other controls.
- Priority, evaluated per cycle: reset > clear > load > step. A lower-priority request in the same cycle is dropped, not deferred.
- Clear sets count to 0 and does not pulse wrap.
- Load:
  - Accepted only if every nibble of load_val is <= 9; count takes load_val on the next edge.
  - If any nibble is >= 0xA: count is unchanged, load_err pulses, and a coincident step is dropped.
- Increment:
  - Digit 0 always adds 1. A digit equal to 9 with carry-in becomes 0 and carries out.
  - Carry ripples through every digit in the same cycle (all 9s in digits 0..k roll over together).
  - Latency is 1 cycle from the sampled step to the updated count.
- Decrement:
  - A digit equal to 0 with borrow-in becomes 9 and borrows out.
  - Borrow ripples through all digits in the same cycle.
- Wrap:
  - Up from all 9s gives all 0s; down from all 0s gives all 9s.
  - wrap pulses high on the cycle after that edge, and is otherwise 0.
- mode_wr takes effect on the next cycle. Switching to edge mode while en is high does not step, because en_q already tracks en.
- up_dn is sampled in the same cycle as step and may change every cycle.
- Digits never hold values >= 0xA, because load validation guarantees this.

Optional Feature:
- Macro: BCD_COUNTER_SATURATE_EN.
- Defined:
  - Up at all 9s, or down at all 0s, holds count.
  - wrap still pulses, meaning a saturation event occurred.
  - Adds output port sat (1 bit, reset 0). sat is sticky high after any saturation and is cleared only by reset, clear, or an accepted load.
- Undefined:
  - Modular wrap as described above.
  - No sat port.

Decomposition:
- Package bcd_pkg:
  - constants BCD_MAX = 4'd9 and BCD_MIN = 4'd0;
  - typedef bcd_digit_t as a 4-bit logic;
  - function bcd_valid(nibble) returns nibble <= 9.
- Sub-module bcd_digit:
  - Combinational, one per digit, generated DIGITS times.
  - Inputs: d, up, cin.
  - Outputs: q, cout. cout means carry when up=1 and borrow when up=0.
- The top level holds the registers, the edge detector, priority logic, load validation, and wrap/sat.

Test Plan:
- DIGITS=4, edge mode: reset, then hold en=1 for 10 cycles -> count = 0x0001. Toggle en 0/1 nine more times -> count = 0x0010.
- DIGITS=4, level mode, up: load 0x0998, then en=1 for 3 cycles -> count 0x0999, 0x1000, 0x1001. wrap stays 0.
- DIGITS=4, up from 0x9999: one step -> count = 0x0000 and wrap pulses for exactly one cycle. Down from 0x0000: one step -> 0x9999 and wrap pulses.
- Load 0x12A4 -> load_err pulses and count is unchanged. Load 0x1234 together with step and up_dn=1 -> count = 0x1234 (step dropped).
- Reset asserted mid-count while en=1 in edge mode -> count = 0 during reset. On the first cycle after release with en still 1 -> count = 0x0001.
- With BCD_COUNTER_SATURATE_EN: at 0x9999 apply 3 up steps -> count holds 0x9999, wrap pulses each step, and sat = 1 until clear.
